// File: rtl/wb_commit_unit_if.sv
// ============================================================================
// Module      : wb_commit_unit_if
// Description : Writeback / issue / read-port bundle between the execute
//               stage, the decode stage and wb_commit_unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_commit_unit_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          wb_regWrite;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          issue_valid;
    logic          issue_regWrite;
    logic [AW-1:0] issue_rd;
    logic          issue_rs_use;
    logic          issue_rt_use;
    logic          stall;
    logic [31:0]   retire_count;
    logic          wb_orphan;

    // Execute/decode side drives commits, reads and issues
    modport master (
        output wb_regWrite, wb_rd, wb_data,
        output rs_addr, rt_addr,
        output issue_valid, issue_regWrite, issue_rd, issue_rs_use, issue_rt_use,
        input  rs_data, rt_data, stall, retire_count, wb_orphan
    );

    modport slave (
        input  wb_regWrite, wb_rd, wb_data,
        input  rs_addr, rt_addr,
        input  issue_valid, issue_regWrite, issue_rd, issue_rs_use, issue_rt_use,
        output rs_data, rt_data, stall, retire_count, wb_orphan
    );
endinterface

`default_nettype wire

// File: rtl/wb_commit_unit.sv
// ============================================================================
// Module      : wb_commit_unit
// Description : Commits execute-stage writebacks into a NREG x DW register
//               file, serves two combinational read ports and keeps a
//               per-register in-flight scoreboard that stalls decode on
//               read-after-write or counter saturation.
//               Optional macro WB_BYPASS_EN forwards a same-cycle commit to
//               the read ports and suppresses the matching last-write hazard.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_commit_unit #(
    parameter int NREG = 64,
    parameter int DW   = 32,
    parameter int CW   = 2
) (
    input  wire logic       clock,
    input  wire logic       reset,
    wb_commit_unit_if.slave bus
);

    localparam int            AW        = $clog2(NREG);
    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [CW-1:0] cnt_q  [NREG];
    logic [CW-1:0] cnt_d  [NREG];
    logic [31:0]   retire_count_q;
    logic [31:0]   retire_count_d;
    logic          wb_orphan_q;
    logic          wb_orphan_d;

    logic [DW-1:0]   w_rs_reg;
    logic [DW-1:0]   w_rt_reg;
    logic [CW-1:0]   w_rs_cnt;
    logic [CW-1:0]   w_rt_cnt;
    logic [CW-1:0]   w_wb_cnt;
    logic            w_rs_haz;
    logic            w_rt_haz;
    logic            w_sat_haz;
    logic            w_stall;
    logic            w_accept;
    logic            w_commit;
    logic            w_inc_any;
    logic            w_dec_any;
    logic [NREG-1:0] w_inc_vec;
    logic [NREG-1:0] w_dec_vec;

    // ------------------------------------------------------------------
    // Read ports and scoreboard lookups
    // ------------------------------------------------------------------
    assign w_rs_reg = (bus.rs_addr == '0) ? '0 : regs_q[bus.rs_addr];
    assign w_rt_reg = (bus.rt_addr == '0) ? '0 : regs_q[bus.rt_addr];
    assign w_rs_cnt = cnt_q[bus.rs_addr];
    assign w_rt_cnt = cnt_q[bus.rt_addr];
    assign w_wb_cnt = cnt_q[bus.wb_rd];

`ifdef WB_BYPASS_EN
    logic w_rs_fwd;
    logic w_rt_fwd;

    assign w_rs_fwd = bus.wb_regWrite && (bus.wb_rd == bus.rs_addr) && (bus.rs_addr != '0);
    assign w_rt_fwd = bus.wb_regWrite && (bus.wb_rd == bus.rt_addr) && (bus.rt_addr != '0);

    assign bus.rs_data = w_rs_fwd ? bus.wb_data : w_rs_reg;
    assign bus.rt_data = w_rt_fwd ? bus.wb_data : w_rt_reg;

    // The last outstanding write landing this cycle is forwarded, not waited on
    assign w_rs_haz = bus.issue_rs_use && (w_rs_cnt != '0)
                      && !(w_rs_fwd && (w_rs_cnt == c_cnt_one));
    assign w_rt_haz = bus.issue_rt_use && (w_rt_cnt != '0)
                      && !(w_rt_fwd && (w_rt_cnt == c_cnt_one));
`else
    assign bus.rs_data = w_rs_reg;
    assign bus.rt_data = w_rt_reg;

    assign w_rs_haz = bus.issue_rs_use && (w_rs_cnt != '0);
    assign w_rt_haz = bus.issue_rt_use && (w_rt_cnt != '0);
`endif

    // Refusing the issue is what keeps the counters from ever overflowing
    assign w_sat_haz = bus.issue_regWrite && (cnt_q[bus.issue_rd] == c_cnt_max);
    assign w_stall   = bus.issue_valid && (w_rs_haz || w_rt_haz || w_sat_haz);
    assign w_accept  = bus.issue_valid && !w_stall;

    assign w_commit  = bus.wb_regWrite && (bus.wb_rd != '0);
    assign w_inc_any = w_accept && bus.issue_regWrite && (bus.issue_rd != '0);
    assign w_dec_any = w_commit && (w_wb_cnt != '0);
    assign w_inc_vec = {{(NREG-1){1'b0}}, w_inc_any} << bus.issue_rd;
    assign w_dec_vec = {{(NREG-1){1'b0}}, w_dec_any} << bus.wb_rd;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
        end
        retire_count_d = retire_count_q;
        wb_orphan_d    = wb_orphan_q;

        if (w_commit) begin
            regs_d[bus.wb_rd] = bus.wb_data;
        end

        // rd 0 still counts as a retirement even though nothing is written
        if (bus.wb_regWrite) begin
            retire_count_d = retire_count_q + 32'd1;
        end

        if (w_commit && (w_wb_cnt == '0)) begin
            wb_orphan_d = 1'b1;
        end

        for (int r = 0; r < NREG; r++) begin
            case ({w_inc_vec[r], w_dec_vec[r]})
                2'b10:   cnt_d[r] = cnt_q[r] + c_cnt_one;
                2'b01:   cnt_d[r] = cnt_q[r] - c_cnt_one;
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            retire_count_q <= '0;
            wb_orphan_q    <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            retire_count_q <= retire_count_d;
            wb_orphan_q    <= wb_orphan_d;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.retire_count = retire_count_q;
    assign bus.wb_orphan    = wb_orphan_q;

endmodule

`default_nettype wire

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Consumer end of the execute/writeback interface: takes the registered writeback triple (regWrite, rd, result) leaving the execute stage and commits it to a 64 x 32 register file.
- Serves the decode stage with two combinational read ports.
- Keeps a per-register in-flight scoreboard fed by decode issue, and raises stall on read-after-write or scoreboard-saturation hazards.
- Sits between the execute stage's writeback outputs and the decode/ID-EX boundary.

Parameters:
- NREG, 64, number of architectural registers (address width 6).
- DW, 32, data width.
- CW, 2, scoreboard counter width per register (max in-flight writes per register = 2^CW-1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wb_regWrite  in  1  commit strobe from execute stage.
- wb_rd  in  6  commit destination.
- wb_data  in  32  commit value (writeback mux result).
- rs_addr  in  6  read port A address.
- rt_addr  in  6  read port B address.
- rs_data  out  32  read port A data.
- rt_data  out  32  read port B data.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_regWrite  in  1  issued instruction will write issue_rd.
- issue_rd  in  6  issued instruction destination.
- issue_rs_use  in  1  issued instruction reads rs_addr.
- issue_rt_use  in  1  issued instruction reads rt_addr.
- stall  out  1  issue refused this cycle; decode must hold.
- retire_count  out  32  number of commits accepted.
- wb_orphan  out  1  sticky error: commit to a register with zero pending count.

Behaviour:
- Reset (async): all registers = 0, all counters = 0, retire_count = 0, wb_orphan = 0. stall is combinational and equals 0 while issue_valid = 0.
- Register 0 is hardwired to zero:
  - Reads of address 0 return 0.
  - Commits to rd 0 are not written but do increment retire_count.
  - Issues to rd 0 never touch the scoreboard.
- Commit: on a clock edge with wb_regWrite=1 and wb_rd!=0, regs[wb_rd] <= wb_data. retire_count += 1 on every wb_regWrite=1 edge, wrapping at 2^32.
- Reads: combinational from the register array, so a same-cycle commit is visible only after the edge.
- Pending: pending[r] = (cnt[r] != 0).
- Hazard: stall = issue_valid & ((issue_rs_use & pending[rs_addr]) | (issue_rt_use & pending[rt_addr]) | (issue_regWrite & cnt[issue_rd] == 2^CW-1)).
- Accept: issue is accepted when issue_valid=1 and stall=0.
- Counter update per edge, for r != 0:
  - inc = accepted issue with issue_regWrite=1 and issue_rd=r.
  - dec = wb_regWrite=1, wb_rd=r, cnt[r]!=0.
  - inc & dec -> cnt unchanged; inc only -> +1; dec only -> -1.
  - Saturation cannot occur, because an issue that would saturate stalls instead.
- Orphan: commit with wb_regWrite=1, wb_rd!=0, cnt[wb_rd]=0 -> register is still written, cnt stays 0, wb_orphan <= 1 until reset.
- Reset asserted mid-operation clears the scoreboard and the register file immediately. Commits arriving after reset that belong to pre-reset issues are flagged as orphans.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - rs_data = wb_data when wb_regWrite & wb_rd==rs_addr & rs_addr!=0; same rule for rt_data.
  - The hazard term for a source whose cnt==1 and which is being committed this cycle is suppressed (no stall; value is forwarded).
- Undefined: no forwarding. A same-cycle commit still stalls the dependent issue for one cycle, and the read sees the new value next cycle.

Test Plan:
- Reset then read all 64 addresses -> every read returns 0. retire_count=0, wb_orphan=0.
- Issue rd=5 (regWrite=1). Next cycle issue with rs_addr=5, rs_use=1 -> stall=1. Commit wb_rd=5, wb_data=0xDEADBEEF -> without WB_BYPASS_EN stall is held through that cycle, released next cycle, and rs_data=0xDEADBEEF. With WB_BYPASS_EN stall=0 in the commit cycle and rs_data=0xDEADBEEF combinationally.
- Three accepted issues to rd=9 (cnt=3). Fourth issue to rd=9 -> stall=1 until one commit to 9 lands. Three commits -> cnt=0, pending clear.
- Same-edge accepted issue rd=7 and commit rd=7 with cnt[7]=1 -> cnt[7] stays 1, regs[7] updated.
- Commit wb_rd=12, wb_data=0x1234 with no prior issue -> regs[12]=0x1234, wb_orphan=1 sticky, retire_count +1. Commit rd=0, data=0xFFFF -> regs[0] reads 0, retire_count +1.
- Assert reset asynchronously between edges with cnt[3]=2 and regs[3]=0x55 -> all outputs and state zero immediately. Subsequent issue reading r3 -> stall=0.
